seq_gen: RTL and testbench

- Serial pattern transmitter; the driving end of the serial `x` line that our sequence-detector FSMs consume.
- Accepts a parallel pattern, length and repeat count on a start strobe.
- Shifts the pattern out MSB-first, one bit per clock, with a valid flag and a frame marker.
- Optional idle gap between repeats.
- Used as a stimulus source and as an on-chip pattern generator feeding detector blocks.

---
 rtl/seq_gen.sv | 182 ++++++++++++++++++
 tb/tb_seq_gen.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/seq_gen.sv
// Serial pattern transmitter: shifts a parallel pattern out MSB-first with valid/frame markers.
// Define SEQ_GEN_LOOP_EN to add the i_stop port and infinite repetition when reps is all-ones.
module seq_gen #(
  parameter int PAT_W   = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 4,
  parameter int GAP_CYC = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [PAT_W-1:0] i_pat,
  input  logic [LEN_W-1:0] i_len,
  input  logic [CNT_W-1:0] i_reps,
`ifdef SEQ_GEN_LOOP_EN
  input  logic             i_stop,
`endif
  output logic             o_x_out,
  output logic             o_x_vld,
  output logic             o_frame,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int GAP_LOAD_I = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
  localparam int GAP_W      = (GAP_LOAD_I > 0) ? $clog2(GAP_LOAD_I + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_LOAD_I);
  localparam logic [LEN_W-1:0] PAT_W_L  = LEN_W'(PAT_W);

  logic [1:0]       r_state;
  logic [PAT_W-1:0] r_pat;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [GAP_W-1:0] r_gap;
  logic             r_stop;

  logic [1:0]       w_state_n;
  logic [PAT_W-1:0] w_pat_n;
  logic [LEN_W-1:0] w_len_n;
  logic [LEN_W-1:0] w_idx_n;
  logic [CNT_W-1:0] w_cnt_n;
  logic [GAP_W-1:0] w_gap_n;
  logic             w_stop_n;
  logic             w_vld_n;
  logic             w_frame_n;
  logic             w_busy_n;
  logic             w_done_n;
  logic             w_xout_n;
  logic [PAT_W-1:0] w_emit_pat;
  logic [LEN_W-1:0] w_emit_idx;
  logic [PAT_W-1:0] w_sh;
  logic [LEN_W-1:0] w_len_clamp;
  logic             w_stop_in;
  logic             w_inf;

  assign w_len_clamp = (i_len > PAT_W_L) ? PAT_W_L : i_len;

`ifdef SEQ_GEN_LOOP_EN
  assign w_stop_in = i_stop;
  assign w_inf     = (r_cnt == {CNT_W{1'b1}});
`else
  assign w_stop_in = 1'b0;
  assign w_inf     = 1'b0;
`endif

  // Next-state and next-output logic; outputs are registered from these values.
  always_comb begin
    w_state_n  = r_state;
    w_pat_n    = r_pat;
    w_len_n    = r_len;
    w_idx_n    = r_idx;
    w_cnt_n    = r_cnt;
    w_gap_n    = r_gap;
    w_stop_n   = r_stop;
    w_vld_n    = 1'b0;
    w_frame_n  = 1'b0;
    w_busy_n   = 1'b0;
    w_done_n   = 1'b0;
    w_emit_pat = r_pat;
    w_emit_idx = '0;
    case (r_state)
      S_IDLE: begin
        w_stop_n = 1'b0;
        if (i_start) begin
          w_pat_n  = i_pat;
          w_len_n  = w_len_clamp;
          w_cnt_n  = i_reps;
          w_busy_n = 1'b1;
          if (w_len_clamp != '0) begin
            w_state_n  = S_SHIFT;
            w_idx_n    = w_len_clamp - LEN_W'(1);
            w_vld_n    = 1'b1;
            w_frame_n  = 1'b1;
            w_emit_pat = i_pat;
            w_emit_idx = w_len_clamp - LEN_W'(1);
          end else begin
            w_state_n = S_DONE;
            w_done_n  = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        w_busy_n = 1'b1;
        w_stop_n = r_stop | w_stop_in;
        if (r_idx != '0) begin
          w_idx_n    = r_idx - LEN_W'(1);
          w_vld_n    = 1'b1;
          w_emit_idx = r_idx - LEN_W'(1);
        end else if ((r_cnt == '0) || w_stop_n) begin
          w_state_n = S_DONE;
          w_done_n  = 1'b1;
        end else begin
          if (!w_inf) w_cnt_n = r_cnt - CNT_W'(1);
          w_idx_n = r_len - LEN_W'(1);
          if (GAP_CYC != 0) begin
            w_state_n = S_GAP;
            w_gap_n   = GAP_LOAD;
          end else begin
            w_vld_n    = 1'b1;
            w_frame_n  = 1'b1;
            w_emit_idx = r_len - LEN_W'(1);
          end
        end
      end
      S_GAP: begin
        w_busy_n = 1'b1;
        w_stop_n = r_stop | w_stop_in;
        if (r_gap == '0) begin
          w_state_n  = S_SHIFT;
          w_vld_n    = 1'b1;
          w_frame_n  = 1'b1;
          w_emit_idx = r_idx;
        end else begin
          w_gap_n = r_gap - GAP_W'(1);
        end
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
    w_sh     = w_emit_pat >> w_emit_idx;
    w_xout_n = w_vld_n & w_sh[0];
  end

  // State and output registers, cleared asynchronously on reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_pat   <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_stop  <= 1'b0;
      o_x_out <= 1'b0;
      o_x_vld <= 1'b0;
      o_frame <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_pat   <= w_pat_n;
      r_len   <= w_len_n;
      r_idx   <= w_idx_n;
      r_cnt   <= w_cnt_n;
      r_gap   <= w_gap_n;
      r_stop  <= w_stop_n;
      o_x_out <= w_xout_n;
      o_x_vld <= w_vld_n;
      o_frame <= w_frame_n;
      o_busy  <= w_busy_n;
      o_done  <= w_done_n;
    end
  end

endmodule

// File: tb/tb_seq_gen.sv
// Directed testbench for seq_gen; observed vector is {x_out, x_vld, frame, busy, done}.
module tb_seq_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] pat = 8'h00;
  logic [3:0] len = 4'd0;
  logic [3:0] reps = 4'd0;
  logic       xOut, xVld, frame, busy, done;
  logic [4:0] obs;
  int         checkCount = 0;
  int         passCount = 0;
`ifdef SEQ_GEN_LOOP_EN
  logic       stop = 1'b0;
`endif

  seq_gen dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_pat   (pat),
    .i_len   (len),
    .i_reps  (reps),
`ifdef SEQ_GEN_LOOP_EN
    .i_stop  (stop),
`endif
    .o_x_out (xOut),
    .o_x_vld (xVld),
    .o_frame (frame),
    .o_busy  (busy),
    .o_done  (done)
  );

  assign obs = {xOut, xVld, frame, busy, done};

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge; on return the outputs show cycle 1 of the transfer.
  task automatic applyStimulus(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
    pat   = p;
    len   = l;
    reps  = r;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic runMeasure(input int maxCyc, output int vldCnt, output int doneCyc);
    vldCnt  = 0;
    doneCyc = 0;
    for (int c = 1; c <= maxCyc; c++) begin
      if (xVld) vldCnt++;
      if (done) begin
        doneCyc = c;
        break;
      end
      tick();
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [4:0] exp1 [5];
    logic [4:0] exp4 [6];
    logic [7:0] b2;
    logic [4:0] e;
    int         vldCnt, doneCyc;

    tick();
    tick();
    checkOutput("reset_state", 32'(obs), 32'h0);
    rst_n = 1'b1;
    tick();

    // pat 05, len 3: bits 1,0,1 then done
    exp1 = '{5'b11110, 5'b01010, 5'b11010, 5'b00011, 5'b00000};
    applyStimulus(8'h05, 4'd3, 4'd0);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("t1_c%0d", i + 1), 32'(obs), 32'(exp1[i]));
      tick();
    end

    // pat B2, len 8, reps 1, one gap cycle
    b2 = 8'b1011_0010;
    applyStimulus(8'hB2, 4'd8, 4'd1);
    for (int c = 1; c <= 19; c++) begin
      if (c <= 8)       e = {b2[8 - c], 1'b1, (c == 1), 1'b1, 1'b0};
      else if (c == 9)  e = 5'b00010;
      else if (c <= 17) e = {b2[17 - c], 1'b1, (c == 10), 1'b1, 1'b0};
      else if (c == 18) e = 5'b00011;
      else              e = 5'b00000;
      checkOutput($sformatf("t2_c%0d", c), 32'(obs), 32'(e));
      if (c < 19) tick();
    end

    // len 0: immediate done, no bits
    applyStimulus(8'hFF, 4'd0, 4'd3);
    checkOutput("t3_c1", 32'(obs), 32'b00011);
    tick();
    checkOutput("t3_c2", 32'(obs), 32'b00000);

    // start during SHIFT is ignored; pattern F6 len 4 sends 0,1,1,0
    exp4 = '{5'b01110, 5'b11010, 5'b11010, 5'b01010, 5'b00011, 5'b00000};
    vldCnt = 0;
    applyStimulus(8'hF6, 4'd4, 4'd0);
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("t4_c%0d", i + 1), 32'(obs), 32'(exp4[i]));
      if (xVld) vldCnt++;
      if (i == 1) begin
        pat   = 8'hFF;
        len   = 4'd8;
        start = 1'b1;
      end
      if (i == 2) start = 1'b0;
      if (i < 5) tick();
    end
    checkOutput("t4_vld_count", 32'(vldCnt), 32'd4);
    applyStimulus(8'h03, 4'd2, 4'd0);
    checkOutput("t4_next_c1", 32'(obs), 32'b11110);
    tick();
    checkOutput("t4_next_c2", 32'(obs), 32'b11010);
    tick();
    checkOutput("t4_next_c3", 32'(obs), 32'b00011);
    tick();

    // asynchronous reset mid-shift, then a fresh single-bit transfer
    applyStimulus(8'h15, 4'd5, 4'd0);
    checkOutput("t5_c1", 32'(obs), 32'b11110);
    tick();
    checkOutput("t5_c2", 32'(obs), 32'b01010);
    #2 rst_n = 1'b0;
    #1 checkOutput("t5_async_reset", 32'(obs), 32'h0);
    #2 rst_n = 1'b1;
    tick();
    checkOutput("t5_idle_after_reset", 32'(obs), 32'h0);
    applyStimulus(8'h01, 4'd1, 4'd0);
    checkOutput("t5_fresh_c1", 32'(obs), 32'b11110);
    tick();
    checkOutput("t5_fresh_c2", 32'(obs), 32'b00011);
    tick();
    checkOutput("t5_fresh_c3", 32'(obs), 32'b00000);

    // len above PAT_W is clamped to 8 bits
    applyStimulus(8'h81, 4'd15, 4'd0);
    checkOutput("t6_first_bit", 32'(obs), 32'b11110);
    runMeasure(30, vldCnt, doneCyc);
    checkOutput("t6_vld_count", 32'(vldCnt), 32'd8);
    checkOutput("t6_done_cycle", 32'(doneCyc), 32'd9);

`ifndef SEQ_GEN_LOOP_EN
    // reps all-ones: 16 single-bit transmissions separated by gaps
    applyStimulus(8'h01, 4'd1, 4'hF);
    runMeasure(100, vldCnt, doneCyc);
    checkOutput("t7_vld_count", 32'(vldCnt), 32'd16);
    checkOutput("t7_done_cycle", 32'(doneCyc), 32'd32);
`else
    // infinite 101 frames, stop mid-frame finishes that frame
    applyStimulus(8'h05, 4'd3, 4'hF);
    for (int c = 1; c <= 9; c++) begin
      case (c)
        1, 5:    e = 5'b11110;
        2, 6:    e = 5'b01010;
        3, 7:    e = 5'b11010;
        4:       e = 5'b00010;
        8:       e = 5'b00011;
        default: e = 5'b00000;
      endcase
      checkOutput($sformatf("t8_c%0d", c), 32'(obs), 32'(e));
      if (c == 6) stop = 1'b1;
      if (c == 7) stop = 1'b0;
      if (c < 9) tick();
    end
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
